riscv_lsu: RTL and testbench

Load-store unit between the core datapath and the data memory. It takes the memory control fields the main decoder produces (request, write enable, access size) together with the ALU-computed address and the store data, and runs one memory transaction per instruction. It generates byte enables, aligns store data, and sign- or zero-extends load data. It stalls the core until the memory responds and flags misaligned or illegal-size accesses without issuing them.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/riscv_lsu_load_align.sv | 27 ++
 rtl/riscv_lsu.sv | 119 +++++++++++
 tb/tb_riscv_lsu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store size encodings, LSU state type and
// the legality / byte-enable / store-lane helpers used by the load-store unit.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [0:0] {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_t;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; unknown sizes never issue.
    function automatic logic lsu_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            LDST_B, LDST_BU: ok = 1'b1;
            LDST_H, LDST_HU: ok = (addr_lo[0] == 1'b0);
            LDST_W:          ok = (addr_lo == 2'b00);
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << addr_lo;
            LDST_H, LDST_HU: be = 4'b0011 << {addr_lo[1], 1'b0};
            LDST_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_store_data(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] data;
        case (size)
            LDST_B, LDST_BU: data = {4{wd[7:0]}};
            LDST_H, LDST_HU: data = {2{wd[15:0]}};
            default:         data = wd;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Load-data extraction: selects the addressed byte/halfword of the memory
// word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [15:0] lane_s;

    // Shift the addressed lane down to bit 0 then extend by access type.
    always_comb begin
        lane_s = 16'(rd >> {addr_lo, 3'b000});
        case (size)
            LDST_B:  result = {{24{lane_s[7]}}, lane_s[7:0]};
            LDST_BU: result = {24'h000000, lane_s[7:0]};
            LDST_H:  result = {{16{lane_s[15]}}, lane_s};
            LDST_HU: result = {16'h0000, lane_s};
            LDST_W:  result = rd;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: one memory transaction per instruction, stalling the core
// until the memory responds; misaligned or illegal-size accesses fault instead.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_t  state_r;
    logic        req_we_r;
    logic [2:0]  req_size_r;
    logic [31:0] req_addr_r;
    logic [31:0] req_wd_r;
    logic        legal_s;
    logic [31:0] load_data_s;

    assign legal_s = lsu_legal(core_size_i, core_addr_i[1:0]);

    lsu_load_align u_load_align (
        .rd      (mem_rd_i),
        .size    (req_size_r),
        .addr_lo (req_addr_r[1:0]),
        .result  (load_data_s)
    );

    // State and request capture; the WAIT phase works only from captured values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= LSU_IDLE;
            req_we_r   <= 1'b0;
            req_size_r <= 3'd0;
            req_addr_r <= 32'h0000_0000;
            req_wd_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                LSU_IDLE: begin
                    if (core_req_i && legal_s) begin
                        state_r    <= LSU_WAIT;
                        req_we_r   <= core_we_i;
                        req_size_r <= core_size_i;
                        req_addr_r <= core_addr_i;
                        req_wd_r   <= core_wd_i;
                    end else begin
                        state_r <= LSU_IDLE;
                    end
                end
                LSU_WAIT: begin
                    if (mem_ready_i) begin
                        state_r <= LSU_IDLE;
                    end else begin
                        state_r <= LSU_WAIT;
                    end
                end
                default: state_r <= LSU_IDLE;
            endcase
        end
    end

    // Output decode: the request cycle drives memory straight from the core inputs.
    always_comb begin
        core_rd_o    = 32'h0000_0000;
        core_stall_o = 1'b0;
        core_fault_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = 32'h0000_0000;
        mem_wd_o     = 32'h0000_0000;
        case (state_r)
            LSU_IDLE: begin
                if (core_req_i && legal_s) begin
                    mem_req_o    = 1'b1;
                    mem_we_o     = core_we_i;
                    mem_be_o     = core_we_i ? lsu_byte_en(core_size_i, core_addr_i[1:0]) : 4'b0000;
                    mem_addr_o   = {core_addr_i[31:2], 2'b00};
                    mem_wd_o     = lsu_store_data(core_size_i, core_wd_i);
                    core_stall_o = 1'b1;
                end else if (core_req_i) begin
                    core_fault_o = 1'b1;
                end else begin
                    core_fault_o = 1'b0;
                end
            end
            LSU_WAIT: begin
                mem_req_o  = 1'b1;
                mem_we_o   = req_we_r;
                mem_be_o   = req_we_r ? lsu_byte_en(req_size_r, req_addr_r[1:0]) : 4'b0000;
                mem_addr_o = {req_addr_r[31:2], 2'b00};
                mem_wd_o   = lsu_store_data(req_size_r, req_wd_r);
                if (mem_ready_i) begin
                    core_stall_o = 1'b0;
                    core_rd_o    = req_we_r ? 32'h0000_0000 : load_data_s;
                end else begin
                    core_stall_o = 1'b1;
                end
            end
            default: begin
                core_stall_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a transaction-level model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int checks = 0;
    int errors = 0;

    riscv_lsu dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_fault_o (core_fault_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [2:0] s);
        case (s)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_legal(input logic [2:0] s, input logic [31:0] a);
        int n = nbytes(s);
        return (n != 0) && ((a % n) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
        int n = nbytes(s);
        int mask = (1 << n) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
        int n = nbytes(s);
        logic [31:0] o;
        for (int l = 0; l < 4; l++) o[8*l +: 8] = wd[8*(l % n) +: 8];
        return o;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(s);
        logic [31:0] v = rd >> (8 * (a % 4));
        logic [31:0] mask;
        if (n < 4) begin
            mask = 32'((64'd1 << (8 * n)) - 64'd1);
            v = v & mask;
            if ((s == 3'd0 || s == 3'd1) && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    bit          m_busy = 1'b0;
    logic        m_we;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wd_r;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst_i) m_busy <= 1'b0;
        else if (!m_busy && core_req_i && m_legal(core_size_i, core_addr_i)) begin
            m_busy <= 1'b1;
            m_we   <= core_we_i;
            m_size <= core_size_i;
            m_addr <= core_addr_i;
            m_wd_r <= core_wd_i;
        end else if (m_busy && mem_ready_i) m_busy <= 1'b0;
    end

    // Compare every cycle, midway between active edges.
    always @(negedge clk) begin
        logic [31:0] e_rd, e_addr, e_wd;
        logic e_stall, e_fault, e_req, e_we;
        logic [3:0] e_be;
        if (cmp_en && !rst_i) begin
            e_rd = 0; e_stall = 0; e_fault = 0; e_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wd = 0;
            if (!m_busy) begin
                if (core_req_i && !m_legal(core_size_i, core_addr_i)) e_fault = 1;
                else if (core_req_i) begin
                    e_req = 1; e_we = core_we_i; e_stall = 1;
                    e_addr = core_addr_i & ~32'h3;
                    e_be = core_we_i ? m_be(core_size_i, core_addr_i) : 4'h0;
                    e_wd = m_wd(core_size_i, core_wd_i);
                end
            end else begin
                e_req = 1; e_we = m_we; e_addr = m_addr & ~32'h3;
                e_be = m_we ? m_be(m_size, m_addr) : 4'h0;
                e_wd = m_wd(m_size, m_wd_r);
                e_stall = !mem_ready_i;
                if (mem_ready_i && !m_we) e_rd = m_ext(m_size, m_addr, mem_rd_i);
            end
            check("m_req", 32'(mem_req_o), 32'(e_req));
            check("m_stall", 32'(core_stall_o), 32'(e_stall));
            check("m_fault", 32'(core_fault_o), 32'(e_fault));
            check("m_rd", core_rd_o, e_rd);
            if (e_req) begin
                check("m_we", 32'(mem_we_o), 32'(e_we));
                check("m_be", 32'(mem_be_o), 32'(e_be));
                check("m_addr", mem_addr_o, e_addr);
                if (e_we) check("m_wd", mem_wd_o, e_wd);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        core_req_i = req; core_we_i = we; core_size_i = sz; core_addr_i = a; core_wd_i = wd;
    endtask

    logic [31:0] lane_b  [4];
    logic [31:0] lane_bu [4];

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        lane_b  = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
        lane_bu = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};
        rst_i = 1'b1; mem_rd_i = 32'h0; mem_ready_i = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        cyc(); cyc();
        rst_i = 1'b0;
        cmp_en = 1'b1;
        #3;
        check("rst_req", 32'(mem_req_o), 32'h0);
        check("rst_stall", 32'(core_stall_o), 32'h0);
        check("rst_rd", core_rd_o, 32'h0);

        // store byte to lane 3
        cyc(); drive(1'b1, 1'b1, 3'd0, 32'h0000_1003, 32'hAABB_CC5A); #3;
        check("sb_addr", mem_addr_o, 32'h0000_1000);
        check("sb_be", 32'(mem_be_o), 32'h8);
        check("sb_wd", mem_wd_o, 32'h5A5A_5A5A);
        check("sb_we", 32'(mem_we_o), 32'h1);
        check("sb_stall0", 32'(core_stall_o), 32'h1);
        cyc(); mem_ready_i = 1'b1; #3;
        check("sb_stall1", 32'(core_stall_o), 32'h0);
        check("sb_req1", 32'(mem_req_o), 32'h1);
        cyc(); drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0); mem_ready_i = 1'b0;

        // signed / unsigned halfword loads, ready on the fourth cycle
        for (int k = 0; k < 2; k++) begin
            cyc(); drive(1'b1, 1'b0, (k == 0) ? 3'd1 : 3'd5, 32'h0000_2002, 32'h0);
            mem_rd_i = 32'h8123_4567;
            for (int c = 0; c < 3; c++) begin
                #3; check("lh_stall", 32'(core_stall_o), 32'h1);
                cyc();
            end
            mem_ready_i = 1'b1; #3;
            check("lh_stall_rel", 32'(core_stall_o), 32'h0);
            check("lh_rd", core_rd_o, (k == 0) ? 32'hFFFF_8123 : 32'h0000_8123);
            cyc(); drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0); mem_ready_i = 1'b0;
        end

        // misaligned word, then illegal size
        cyc(); drive(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0); #3;
        check("mis_fault", 32'(core_fault_o), 32'h1);
        check("mis_req", 32'(mem_req_o), 32'h0);
        check("mis_stall", 32'(core_stall_o), 32'h0);
        cyc(); drive(1'b1, 1'b1, 3'd3, 32'h0000_3000, 32'h0); #3;
        check("ill_fault", 32'(core_fault_o), 32'h1);
        check("ill_req", 32'(mem_req_o), 32'h0);
        cyc(); drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0); #3;
        check("fault_pulse", 32'(core_fault_o), 32'h0);

        // back-to-back LW then SW, ready held high
        mem_ready_i = 1'b1; mem_rd_i = 32'h1234_5678;
        cyc(); drive(1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
        cyc(); core_addr_i = 32'h0000_0044; #3;
        check("b2b_lw_addr", mem_addr_o, 32'h0000_0010);
        check("b2b_lw_rd", core_rd_o, 32'h1234_5678);
        cyc(); drive(1'b1, 1'b1, 3'd2, 32'h0000_0020, 32'hCAFE_F00D); #3;
        check("b2b_sw_stall", 32'(core_stall_o), 32'h1);
        cyc(); core_addr_i = 32'h0000_0088; #3;
        check("b2b_sw_addr", mem_addr_o, 32'h0000_0020);
        check("b2b_sw_be", 32'(mem_be_o), 32'hF);
        check("b2b_sw_stall1", 32'(core_stall_o), 32'h0);
        cyc(); drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0); mem_ready_i = 1'b0;

        // reset while waiting
        cyc(); drive(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0);
        cyc(); rst_i = 1'b1;
        cyc(); rst_i = 1'b0; drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0); #3;
        check("rw_req", 32'(mem_req_o), 32'h0);
        check("rw_stall", 32'(core_stall_o), 32'h0);

        // byte loads on every lane, signed and unsigned
        mem_rd_i = 32'h80FF_7F01;
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 4; l++) begin
                cyc(); drive(1'b1, 1'b0, (k == 0) ? 3'd0 : 3'd4, 32'h0000_5000 + 32'(l), 32'h0);
                cyc(); mem_ready_i = 1'b1; #3;
                check("lb_lane", core_rd_o, (k == 0) ? lane_b[l] : lane_bu[l]);
                cyc(); drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0); mem_ready_i = 1'b0;
            end
        end

        cyc(); cyc();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
